// File: rtl/cms_pkg.sv
// cms_pkg: control addresses, FSM state and packet field layout shared by the trace packetizer (CMS_TIMESTAMP_EN adds a 64-bit timestamp field).
package cms_pkg;
  localparam logic [7:0] CMS_CTRL_START = 8'h00;
  localparam logic [7:0] CMS_CTRL_STOP  = 8'h01;
  localparam logic [7:0] CMS_CTRL_TLAST = 8'h02;
  localparam logic [7:0] CMS_CTRL_PC_LO = 8'h03;
  localparam logic [7:0] CMS_CTRL_PC_HI = 8'h04;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;
  function automatic int instr_lsb(int xlen);
    return xlen;
  endfunction
  function automatic int cnt_lsb(int xlen);
    return instr_lsb(xlen) + 32;
  endfunction
  function automatic int ts_lsb(int xlen, int n, int w);
    return cnt_lsb(xlen) + n * w;
  endfunction
  function automatic int pkt_width(int xlen, int n, int w);
`ifdef CMS_TIMESTAMP_EN
    return ts_lsb(xlen, n, w) + 64;
`else
    return ts_lsb(xlen, n, w);
`endif
  endfunction
endpackage

// File: rtl/cms_sync_fifo.sv
// cms_sync_fifo: synchronous FIFO with exact occupancy, per-entry last flag and a port to force the tail entry's last flag.
module cms_sync_fifo #(
  parameter int W     = 160,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          din_last,
  input  logic          pop,
  input  logic          tail_set,
  output logic [W-1:0]  dout,
  output logic          dout_last,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   occ
);
  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] last;
  logic [AW-1:0]    wr, rd;
  assign empty     = occ == '0;
  assign full      = occ == (AW+1)'(DEPTH);
  assign dout      = empty ? '0 : mem[rd];
  assign dout_last = !empty && last[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr  <= '0;
      rd  <= '0;
      occ <= '0;
    end else begin
      wr  <= wr + AW'(push);
      rd  <= rd + AW'(pop);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Storage is not reset: occupancy gates everything that leaves the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr]  <= din;
      last[wr] <= din_last;
    end
    if (tail_set) last[wr - AW'(1)] <= 1'b1;
  end
endmodule

// File: rtl/cms_trace_packetizer.sv
// cms_trace_packetizer: packs retired PC/instr and event counters into AXI-Stream beats via a FIFO; CMS_TIMESTAMP_EN appends a 64-bit cycle stamp.
module cms_trace_packetizer
  import cms_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int NUM_EVENTS     = 8,
  parameter int CNT_W          = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DEPTH          = 16,
  parameter int HALT_MARGIN    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr,
  input  logic [XLEN-1:0]           pc,
  input  logic                      instr_valid,
  input  logic [NUM_EVENTS-1:0]     performance_events,
  input  logic [7:0]                ctrl_addr,
  input  logic [63:0]               ctrl_wdata,
  input  logic                      ctrl_write_enable,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                      M_AXIS_tlast,
  output logic                      halt_cpu,
  output logic [63:0]               item_count
);
  localparam int PW = pkt_width(XLEN, NUM_EVENTS, CNT_W);
  localparam int OW = $clog2(DEPTH) + 1;
  if (AXI_DATA_WIDTH < PW) begin : g_width_chk
    $error("AXI_DATA_WIDTH %0d narrower than packet width %0d", AXI_DATA_WIDTH, PW);
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH %0d must be a power of 2 and >= 4", DEPTH);
  end
  state_t                      state;
  logic                        we_q, cmd_v;
  logic [7:0]                  cmd_addr;
  logic [63:0]                 cmd_data;
  logic [31:0]                 tlast_interval, tcount;
  logic [XLEN-1:0]             pc_lo, pc_hi;
  logic [CNT_W-1:0]            cnt [NUM_EVENTS];
  logic [NUM_EVENTS*CNT_W-1:0] cnt_next;
  logic [PW-1:0]               pkt, dout;
  logic                        dout_last, empty, full;
  logic [OW-1:0]               occ;
  logic run, flushing, start, stop, pop, cap, push_cap, cap_last, live, tail_set, zero_push;
  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
    assign cnt_next[i*CNT_W +: CNT_W] = cnt[i] + CNT_W'(performance_events[i]);
  end
`ifdef CMS_TIMESTAMP_EN
  logic [63:0] ts;
  assign pkt = {ts, cnt_next, instr, pc};
  always_ff @(posedge clk or posedge rst)
    if (rst) ts <= '0;
    else ts <= start ? '0 : run ? ts + 64'd1 : ts;
`else
  assign pkt = {cnt_next, instr, pc};
`endif
  assign run       = state == ST_RUN;
  assign flushing  = state == ST_FLUSH;
  assign start     = cmd_v && cmd_addr == CMS_CTRL_START && state == ST_IDLE;
  assign stop      = cmd_v && cmd_addr == CMS_CTRL_STOP && run;
  assign pop       = !empty && M_AXIS_tready;
  assign cap       = run && instr_valid && pc >= pc_lo && pc <= pc_hi;
  assign push_cap  = cap && (!full || pop);
  assign cap_last  = tlast_interval != 0 && tcount == tlast_interval - 32'd1;
  // An entry leaving this cycle cannot carry the end marker, so flush then emits a fresh zero beat.
  assign live      = occ > OW'(pop);
  assign tail_set  = flushing && live;
  assign zero_push = flushing && !live;
  cms_sync_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_cap || zero_push),
    .din      (zero_push ? '0 : pkt),
    .din_last (zero_push || cap_last),
    .pop      (pop),
    .tail_set (tail_set),
    .dout     (dout),
    .dout_last(dout_last),
    .empty    (empty),
    .full     (full),
    .occ      (occ)
  );
  assign M_AXIS_tvalid = !empty;
  assign M_AXIS_tdata  = AXI_DATA_WIDTH'(dout);
  assign M_AXIS_tlast  = dout_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q           <= 1'b0;
      cmd_v          <= 1'b0;
      cmd_addr       <= '0;
      cmd_data       <= '0;
      state          <= ST_IDLE;
      tlast_interval <= '0;
      tcount         <= '0;
      pc_lo          <= '0;
      pc_hi          <= '1;
      item_count     <= '0;
      halt_cpu       <= 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) cnt[i] <= '0;
    end else begin
      we_q     <= ctrl_write_enable;
      cmd_v    <= ctrl_write_enable && !we_q;
      cmd_addr <= ctrl_addr;
      cmd_data <= ctrl_wdata;
      halt_cpu <= occ >= OW'(DEPTH - HALT_MARGIN);
      if (cmd_v && cmd_addr == CMS_CTRL_TLAST) tlast_interval <= cmd_data[31:0];
      if (cmd_v && cmd_addr == CMS_CTRL_PC_LO) pc_lo <= XLEN'(cmd_data);
      if (cmd_v && cmd_addr == CMS_CTRL_PC_HI) pc_hi <= XLEN'(cmd_data);
      state      <= start ? ST_RUN : stop ? ST_FLUSH : flushing ? ST_IDLE : state;
      item_count <= start ? '0 : item_count + 64'(push_cap);
      tcount     <= start ? '0 : push_cap ? (cap_last ? '0 : tcount + 32'd1) : tcount;
      for (int i = 0; i < NUM_EVENTS; i++)
        cnt[i] <= (start || push_cap) ? '0 : run ? cnt_next[i*CNT_W +: CNT_W] : cnt[i];
    end
endmodule

// File: tb/tb_cms_trace_packetizer.sv
// tb_cms_trace_packetizer: queue-based reference model checked every cycle, plus directed literal checks and a random phase.
module tb_cms_trace_packetizer;
  logic         clk = 0, rst = 0;
  logic [31:0]  instr = 0;
  logic [63:0]  pc = 0;
  logic         instr_valid = 0;
  logic [7:0]   performance_events = 0;
  logic [7:0]   ctrl_addr = 0;
  logic [63:0]  ctrl_wdata = 0;
  logic         ctrl_write_enable = 0;
  logic         M_AXIS_tvalid, M_AXIS_tlast, halt_cpu;
  logic         M_AXIS_tready = 1;
  logic [255:0] M_AXIS_tdata;
  logic [63:0]  item_count;

  cms_trace_packetizer dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .performance_events(performance_events), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tlast(M_AXIS_tlast), .halt_cpu(halt_cpu), .item_count(item_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, beats leaving the stream appended to a log.
  logic [255:0] qd[$], logd[$];
  bit           ql[$], logl[$];
  int           m_state, occ0;
  bit           m_we_prev, m_pend, pop_m, run_m, st_m, sp_m, halt_m, mlast;
  logic [7:0]   m_paddr, m_cnt[8], val[8];
  logic [63:0]  m_pdata, m_lo, m_hi, m_item, m_ts;
  logic [31:0]  m_tli, m_tcnt;
  logic [255:0] pk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qd.delete(); ql.delete();
      m_state = 0; m_we_prev = 0; m_pend = 0; m_tli = 0; m_tcnt = 0;
      m_lo = 0; m_hi = '1; m_item = 0; m_ts = 0; halt_m = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      occ0   = qd.size();
      pop_m  = occ0 > 0 && M_AXIS_tready;
      halt_m = occ0 >= 14;
      run_m  = m_state == 1;
      st_m   = m_pend && m_paddr == 8'h00 && m_state == 0;
      sp_m   = m_pend && m_paddr == 8'h01 && run_m;
      if (pop_m) begin
        logd.push_back(qd.pop_front());
        logl.push_back(ql.pop_front());
      end
      if (m_state == 2) begin
        if (qd.size() > 0) ql[ql.size()-1] = 1;
        else begin qd.push_back('0); ql.push_back(1); end
      end
      if (run_m) begin
        for (int i = 0; i < 8; i++) val[i] = m_cnt[i] + 8'(performance_events[i]);
        if (instr_valid && pc >= m_lo && pc <= m_hi && qd.size() < 16) begin
          pk = '0;
          pk[63:0]  = pc;
          pk[95:64] = instr;
          for (int i = 0; i < 8; i++) pk[96+8*i +: 8] = val[i];
`ifdef CMS_TIMESTAMP_EN
          pk[160 +: 64] = m_ts;
`endif
          mlast = m_tli != 0 && m_tcnt == m_tli - 1;
          qd.push_back(pk);
          ql.push_back(mlast);
          m_tcnt = mlast ? 0 : m_tcnt + 1;
          m_item++;
          for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else
          for (int i = 0; i < 8; i++) m_cnt[i] = val[i];
        m_ts++;
      end
      if (st_m) begin
        m_item = 0; m_tcnt = 0; m_ts = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end
      if (m_pend && m_paddr == 8'h02) m_tli = m_pdata[31:0];
      if (m_pend && m_paddr == 8'h03) m_lo = m_pdata;
      if (m_pend && m_paddr == 8'h04) m_hi = m_pdata;
      m_state   = st_m ? 1 : sp_m ? 2 : m_state == 2 ? 0 : m_state;
      m_pend    = ctrl_write_enable && !m_we_prev;
      m_we_prev = ctrl_write_enable;
      m_paddr   = ctrl_addr;
      m_pdata   = ctrl_wdata;
    end
  end

  always @(negedge clk) begin
    chk("tvalid", M_AXIS_tvalid, qd.size() > 0);
    if (qd.size() > 0) begin
      chk("tdata", M_AXIS_tdata, qd[0]);
      chk("tlast", M_AXIS_tlast, ql[0]);
    end
    chk("halt_cpu", halt_cpu, halt_m);
    chk("item_count", item_count, m_item);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(bit v, logic [63:0] p, logic [7:0] ev);
    step();
    instr_valid = v;
    pc = p;
    instr = $urandom;
    performance_events = ev;
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 0, 0);
  endtask
  task automatic wr(logic [7:0] a, logic [63:0] d);
    drive(0, 0, 0);
    ctrl_addr = a;
    ctrl_wdata = d;
    ctrl_write_enable = 1;
    step();
    ctrl_write_enable = 0;
    repeat (3) step();
  endtask

  int b, caps;
  logic [255:0] e;
  bit exp_last[7] = '{0, 0, 1, 0, 0, 1, 1};

  initial begin
    #1 rst = 1;
    @(negedge clk);
    chk("rst_tvalid", M_AXIS_tvalid, 0);
    chk("rst_tdata", M_AXIS_tdata, 0);
    chk("rst_tlast", M_AXIS_tlast, 0);
    chk("rst_halt", halt_cpu, 0);
    chk("rst_items", item_count, 0);
    step();
    rst = 0;

    b = logd.size();
    wr(8'h00, 0);
    for (int k = 0; k < 5; k++) drive(1, 64'h1000 + 64'(4*k), 0);
    idle(8);
    chk("s1_beats", 256'(logd.size() - b), 5);
    for (int k = 0; k < 5; k++) begin
      e = logd[b+k];
      chk("s1_pc", e[63:0], 64'h1000 + 64'(4*k));
      chk("s1_last", logl[b+k], 0);
    end
    chk("s1_items", item_count, 5);

    b = logd.size();
    wr(8'h01, 0);
    idle(4);
    drive(1, 64'h1100, 0);
    drive(1, 64'h1104, 0);
    idle(4);
    chk("stop_beats", 256'(logd.size() - b), 1);
    e = logd[b];
    chk("stop_zero_data", e, 0);
    chk("stop_zero_last", logl[b], 1);

    wr(8'h02, 3);
    M_AXIS_tready = 0;
    wr(8'h00, 0);
    b = logd.size();
    for (int k = 0; k < 7; k++) drive(1, 64'h1200 + 64'(4*k), 0);
    wr(8'h01, 0);
    M_AXIS_tready = 1;
    idle(12);
    chk("tl_beats", 256'(logd.size() - b), 7);
    for (int k = 0; k < 7; k++) chk("tl_last", logl[b+k], exp_last[k]);

    wr(8'h02, 0);
    wr(8'h03, 64'h2000);
    wr(8'h04, 64'h2FFF);
    wr(8'h00, 0);
    b = logd.size();
    drive(1, 64'h1FFF, 0);
    drive(1, 64'h2000, 0);
    drive(1, 64'h2FFF, 0);
    drive(1, 64'h3000, 0);
    idle(6);
    chk("flt_beats", 256'(logd.size() - b), 2);
    e = logd[b];
    chk("flt_pc0", e[63:0], 64'h2000);
    e = logd[b+1];
    chk("flt_pc1", e[63:0], 64'h2FFF);
    wr(8'h01, 0);
    wr(8'h03, 0);
    wr(8'h04, '1);
    idle(4);

    wr(8'h00, 0);
    b = logd.size();
    repeat (3) drive(0, 0, 8'h01);
    drive(1, 64'h5000, 8'h01);
    drive(1, 64'h5004, 8'h00);
    repeat (300) drive(0, 0, 8'h01);
    drive(1, 64'h5008, 8'h00);
    idle(6);
    chk("ev_beats", 256'(logd.size() - b), 3);
    e = logd[b];
    chk("ev_field_a", e[103:96], 4);
    e = logd[b+1];
    chk("ev_field_b", e[103:96], 0);
    e = logd[b+2];
    chk("ev_field_c", e[103:96], 44);

    M_AXIS_tready = 0;
    b = logd.size();
    caps = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (halt_cpu) break;
      instr_valid = 1;
      pc = 64'h6000 + 64'(4*k);
      performance_events = 0;
      caps++;
    end
    instr_valid = 0;
    chk("halt_caps", caps, 15);
    idle(2);
    chk("halt_set", halt_cpu, 1);
    M_AXIS_tready = 1;
    idle(25);
    chk("halt_clear", halt_cpu, 0);
    chk("halt_beats", 256'(logd.size() - b), 15);

    M_AXIS_tready = 0;
    for (int k = 0; k < 20; k++) drive(1, 64'h7000 + 64'(4*k), 8'($urandom));
    idle(2);
    chk("full_halt", halt_cpu, 1);
    M_AXIS_tready = 1;
    for (int k = 0; k < 6; k++) drive(1, 64'h7100 + 64'(4*k), 8'($urandom));
    M_AXIS_tready = 0;
    for (int k = 0; k < 3; k++) drive(1, 64'h7200 + 64'(4*k), 0);
    idle(2);
    rst = 1;
    #1;
    chk("rst_mid_tvalid", M_AXIS_tvalid, 0);
    chk("rst_mid_halt", halt_cpu, 0);
    chk("rst_mid_items", item_count, 0);
    step();
    rst = 0;

    wr(8'h03, 64'h4000);
    wr(8'h04, 64'hBFFF);
    wr(8'h02, 4);
    wr(8'h00, 0);
    for (int k = 0; k < 1500; k++) begin
      if (k % 300 == 299) wr(8'h02, 64'($urandom_range(0, 5)));
      drive($urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 64'h4000 : 64'($urandom_range(0, 16'hFFFF)),
            ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
      M_AXIS_tready = $urandom_range(0, 3) != 0;
    end
    M_AXIS_tready = 1;
    wr(8'h01, 0);
    idle(30);
    chk("end_drained", M_AXIS_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
